learning_rate_mc: RTL and testbench

- Multi-channel, parametrised PBAS learning-rate (T) update pipeline.
- Per lane computes T' = clamp(T ± num/dmin, tlow, tup), where num = fx ? tinc : tdec.
- Replaces the single-lane, vendor-divider version with an in-house pipelined divider, lane count CH, clock enable, synchronous reset and saturation flags.
- Sits between the PBAS decision stage (supplies fx, dmin) and the background-model memory write-back.

---
 rtl/learning_rate_pkg.sv | 25 ++
 rtl/learning_rate_mc_div.sv | 71 +++++++
 rtl/learning_rate_mc.sv | 206 ++++++++++++++++++++
 tb/tb_learning_rate_mc.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/learning_rate_pkg.sv
// -----------------------------------------------------------------------------
// learning_rate_pkg
// Shared definitions for the multi-lane PBAS learning-rate update pipeline.
//   lr_latency() : input-to-output latency in ce-qualified cycles
//   ERR_CODE     : output word driven when the bounds are misconfigured
//                  (all ones, sliced down to DATA_W by the user)
//   sat_e        : per-lane saturation flag encoding {hit_up, hit_low}
// -----------------------------------------------------------------------------
package learning_rate_pkg;

   typedef enum logic [1:0] {
      SAT_NONE = 2'b00,
      SAT_LOW  = 2'b01,
      SAT_UP   = 2'b10,
      SAT_ERR  = 2'b11
   } sat_e;

   localparam logic [63:0] ERR_CODE = '1;

   // S0 register + one divider stage per quotient bit + add/sub + clamp
   function automatic int lr_latency(input int data_w);
      return data_w + 3;
   endfunction

endpackage

// File: rtl/learning_rate_mc_div.sv
// -----------------------------------------------------------------------------
// div_pipe_u
// Pipelined unsigned restoring divider, one quotient bit per stage, MSB first.
// quo = floor(num / den) appears DATA_W ce-cycles after num/den are presented.
// Carries no valid bit; the caller keeps its own qualifier alongside.
// Divide-by-zero produces an unspecified quotient.
// Ports:
//   clk  : clock
//   ce   : stage enable; 0 holds every stage
//   num  : dividend  (DATA_W)
//   den  : divisor   (DATA_W)
//   quo  : quotient  (DATA_W), registered
// -----------------------------------------------------------------------------
module div_pipe_u #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              ce,
   input  logic [DATA_W-1:0] num,
   input  logic [DATA_W-1:0] den,
   output logic [DATA_W-1:0] quo
);

   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_stage
      logic [DATA_W-1:0] rem_in;
      logic [DATA_W-1:0] nq_in;
      logic [DATA_W-1:0] d_in;
      logic [DATA_W:0]   trial;
      logic              fits;
      // nq_reg holds the not-yet-consumed dividend bits in its upper part and
      // the quotient bits produced so far in its lower part.
      logic [DATA_W-1:0] nq_reg;

      if (gi == 0) begin : g_first
         assign rem_in = '0;
         assign nq_in  = num;
         assign d_in   = den;
      end else begin : g_chain
         assign rem_in = g_stage[gi-1].g_carry.rem_reg;
         assign nq_in  = g_stage[gi-1].nq_reg;
         assign d_in   = g_stage[gi-1].g_carry.d_reg;
      end

      assign trial = {rem_in, nq_in[DATA_W-1]};
      assign fits  = (trial >= {1'b0, d_in});

      always_ff @(posedge clk) begin
         if (ce) begin
            nq_reg <= {nq_in[DATA_W-2:0], fits};
         end
      end

      // The last stage needs no partial remainder or divisor copy.
      if (gi < DATA_W-1) begin : g_carry
         logic [DATA_W-1:0] rem_reg;
         logic [DATA_W-1:0] d_reg;

         // When fits, the true difference is < den, so the low DATA_W bits
         // of the modular subtraction are exact.
         always_ff @(posedge clk) begin
            if (ce) begin
               rem_reg <= fits ? (trial[DATA_W-1:0] - d_in) : trial[DATA_W-1:0];
               d_reg   <= d_in;
            end
         end
      end
   end

   assign quo = g_stage[DATA_W-1].nq_reg;

endmodule

// File: rtl/learning_rate_mc.sv
// -----------------------------------------------------------------------------
// learning_rate_mc
// Multi-lane PBAS learning-rate update: per lane
//    T' = clamp(T +/- num/dmin, tlow, tup),  num = fx ? tinc : tdec
// Pipeline: S0 input register, DATA_W divider stages, S1 add/sub,
// S2 clamp/output register. Latency lr_latency(DATA_W) ce-cycles, one beat
// per ce cycle. Data paths run every cycle; only the valid chain carries tv.
// Optional statistics counters are built when LEARNING_RATE_STATS_EN is
// defined.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   ce                 : pipeline enable; 0 holds everything incl. outputs
//   tv                 : input beat valid (shared by all lanes)
//   tx, fx, dmin       : per-lane current T, foreground flag, min distance
//   tinc, tdec         : increment / decrement numerators
//   tup, tlow          : upper / lower T bounds (sampled at S2)
//   tnv, tnx, tsat     : output valid, new T per lane, {hit_up, hit_low}
//   stat_clr           : (stats build) clears the counters
//   cnt_up, cnt_low    : (stats build) saturating lane-hit counters
// -----------------------------------------------------------------------------
module learning_rate_mc
   import learning_rate_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int CH     = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 tv,
   input  logic [CH*DATA_W-1:0] tx,
   input  logic [CH-1:0]        fx,
   input  logic [CH*DATA_W-1:0] dmin,
   input  logic [DATA_W-1:0]    tinc,
   input  logic [DATA_W-1:0]    tdec,
   input  logic [DATA_W-1:0]    tup,
   input  logic [DATA_W-1:0]    tlow,
   output logic                 tnv,
   output logic [CH*DATA_W-1:0] tnx,
`ifdef LEARNING_RATE_STATS_EN
   input  logic                 stat_clr,
   output logic [31:0]          cnt_up,
   output logic [31:0]          cnt_low,
`endif
   output logic [2*CH-1:0]      tsat
);

   localparam int L = lr_latency(DATA_W);

   // The quotient keeps the Q format of the numerator, so the fraction
   // width only has to fit inside the word.
   if (FRAC_W > DATA_W || DATA_W < 2) begin : g_bad_cfg
      $error("learning_rate_mc: invalid DATA_W/FRAC_W combination");
   end

   // ---------------------------------------------------------------- valid
   logic [L-1:0] vld_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_reg <= '0;
      end else if (ce) begin
         vld_reg <= {vld_reg[L-2:0], tv};
      end
   end

   assign tnv = vld_reg[L-1];

   // ---------------------------------------------------------------- lanes
   for (genvar gi = 0; gi < CH; gi++) begin : g_lane
      logic [DATA_W-1:0]              num_s0_reg;
      logic [DATA_W-1:0]              dmin_s0_reg;
      logic [DATA_W-1:0]              tx_s0_reg;
      logic                           fx_s0_reg;
      logic                           z_s0_reg;
      logic [DATA_W-1:0]              q;
      logic [DATA_W-1:0][DATA_W-1:0]  tx_dly_reg;
      logic [DATA_W-1:0]              fx_dly_reg;
      logic [DATA_W-1:0]              z_dly_reg;
      logic signed [DATA_W+1:0]       r_s1_reg;
      logic                           fx_s1_reg;
      logic                           z_s1_reg;
      logic                           hit_low;
      logic                           hit_up;
      logic [DATA_W-1:0]              tnx_next;
      logic [1:0]                     tsat_next;
      logic [DATA_W-1:0]              tnx_reg;
      logic [1:0]                     tsat_reg;

      // S0
      always_ff @(posedge clk) begin
         if (ce) begin
            num_s0_reg  <= fx[gi] ? tinc : tdec;
            dmin_s0_reg <= dmin[gi*DATA_W +: DATA_W];
            tx_s0_reg   <= tx[gi*DATA_W +: DATA_W];
            fx_s0_reg   <= fx[gi];
            z_s0_reg    <= (dmin[gi*DATA_W +: DATA_W] == '0);
         end
      end

      div_pipe_u #(
         .DATA_W (DATA_W)
      ) u_div (
         .clk (clk),
         .ce  (ce),
         .num (num_s0_reg),
         .den (dmin_s0_reg),
         .quo (q)
      );

      // Side-band delay matching the divider depth
      always_ff @(posedge clk) begin
         if (ce) begin
            tx_dly_reg <= {tx_dly_reg[DATA_W-2:0], tx_s0_reg};
            fx_dly_reg <= {fx_dly_reg[DATA_W-2:0], fx_s0_reg};
            z_dly_reg  <= {z_dly_reg[DATA_W-2:0], z_s0_reg};
         end
      end

      // S1: two extra bits hold both the carry of tx+q and the sign of tx-q
      always_ff @(posedge clk) begin
         if (ce) begin
            if (fx_dly_reg[DATA_W-1]) begin
               r_s1_reg <= $signed({2'b00, tx_dly_reg[DATA_W-1]}) + $signed({2'b00, q});
            end else begin
               r_s1_reg <= $signed({2'b00, tx_dly_reg[DATA_W-1]}) - $signed({2'b00, q});
            end
            fx_s1_reg <= fx_dly_reg[DATA_W-1];
            z_s1_reg  <= z_dly_reg[DATA_W-1];
         end
      end

      // S2 clamp
      assign hit_low = (r_s1_reg <= $signed({2'b00, tlow}));
      assign hit_up  = (r_s1_reg >= $signed({2'b00, tup}));

      always_comb begin
         tnx_next  = r_s1_reg[DATA_W-1:0];
         tsat_next = SAT_NONE;
         if (z_s1_reg) begin
            // A zero distance means an unbounded step: jump to the bound.
            tnx_next  = fx_s1_reg ? tup : tlow;
            tsat_next = fx_s1_reg ? SAT_UP : SAT_LOW;
         end else if (hit_low && hit_up) begin
            tnx_next  = ERR_CODE[DATA_W-1:0];
            tsat_next = SAT_ERR;
         end else if (hit_low) begin
            tnx_next  = tlow;
            tsat_next = SAT_LOW;
         end else if (hit_up) begin
            tnx_next  = tup;
            tsat_next = SAT_UP;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            tnx_reg  <= '0;
            tsat_reg <= SAT_NONE;
         end else if (ce) begin
            tnx_reg  <= tnx_next;
            tsat_reg <= tsat_next;
         end
      end

      assign tnx[gi*DATA_W +: DATA_W] = tnx_reg;
      assign tsat[2*gi +: 2]          = tsat_reg;
   end

`ifdef LEARNING_RATE_STATS_EN
   // ---------------------------------------------------------------- stats
   logic [31:0] n_up;
   logic [31:0] n_low;
   logic [32:0] sum_up;
   logic [32:0] sum_low;
   logic [31:0] cnt_up_reg;
   logic [31:0] cnt_low_reg;

   always_comb begin
      n_up  = '0;
      n_low = '0;
      for (int k = 0; k < CH; k++) begin
         n_up  = n_up  + 32'(tsat[2*k+1]);
         n_low = n_low + 32'(tsat[2*k]);
      end
   end

   assign sum_up  = {1'b0, cnt_up_reg}  + {1'b0, n_up};
   assign sum_low = {1'b0, cnt_low_reg} + {1'b0, n_low};

   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         cnt_up_reg  <= '0;
         cnt_low_reg <= '0;
      end else if (ce && tnv) begin
         cnt_up_reg  <= sum_up[32]  ? '1 : sum_up[31:0];
         cnt_low_reg <= sum_low[32] ? '1 : sum_low[31:0];
      end
   end

   assign cnt_up  = cnt_up_reg;
   assign cnt_low = cnt_low_reg;
`endif

endmodule

// File: tb/tb_learning_rate_mc.sv
// -----------------------------------------------------------------------------
// tb_learning_rate_mc
// Self-checking bench for learning_rate_mc: directed vector table, ce-stall
// and mid-flight reset sequences, and a randomized stream compared against a
// behavioural lane model through an expected-result queue.
// -----------------------------------------------------------------------------
module tb_learning_rate_mc;

   localparam int DW = 16;
   localparam int CH = 3;
   localparam int L  = DW + 3;

   logic              clk;
   logic              rst;
   logic              ce;
   logic              tv;
   logic [CH*DW-1:0]  tx;
   logic [CH-1:0]     fx;
   logic [CH*DW-1:0]  dmin;
   logic [DW-1:0]     tinc;
   logic [DW-1:0]     tdec;
   logic [DW-1:0]     tup;
   logic [DW-1:0]     tlow;
   logic              tnv;
   logic [CH*DW-1:0]  tnx;
   logic [2*CH-1:0]   tsat;
`ifdef LEARNING_RATE_STATS_EN
   logic              stat_clr;
   logic [31:0]       cnt_up;
   logic [31:0]       cnt_low;
`endif

   learning_rate_mc #(
      .DATA_W (DW),
      .FRAC_W (8),
      .CH     (CH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .tv       (tv),
      .tx       (tx),
      .fx       (fx),
      .dmin     (dmin),
      .tinc     (tinc),
      .tdec     (tdec),
      .tup      (tup),
      .tlow     (tlow),
      .tnv      (tnv),
      .tnx      (tnx),
`ifdef LEARNING_RATE_STATS_EN
      .stat_clr (stat_clr),
      .cnt_up   (cnt_up),
      .cnt_low  (cnt_low),
`endif
      .tsat     (tsat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks;
   int failures;

   typedef struct {
      logic [DW-1:0] tx;
      logic          fx;
      logic [DW-1:0] dmin;
      logic [DW-1:0] tinc;
      logic [DW-1:0] tdec;
      logic [DW-1:0] tup;
      logic [DW-1:0] tlow;
      logic [DW-1:0] exp_tnx;
      logic [1:0]    exp_tsat;
   } vec_t;

   typedef struct {
      logic [CH*DW-1:0] tnx;
      logic [2*CH-1:0]  tsat;
   } exp_t;

   vec_t vt [10];
   exp_t sb_q [$];
   exp_t sb_e;
   logic sb_en;

   int               acc_c [$];
   int               out_c [$];
   logic [CH*DW-1:0] out_v [$];
   logic [CH*DW-1:0] exp_v [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Behavioural lane model: plain integer arithmetic on the update rule.
   function automatic void lane_model(input logic [DW-1:0] t, input logic f,
                                      input logic [DW-1:0] d, output logic [DW-1:0] t_new,
                                      output logic [1:0] s);
      int num, q, r;
      if (d == 0) begin
         t_new = f ? tup : tlow;
         s     = f ? 2'b10 : 2'b01;
         return;
      end
      num = f ? int'(tinc) : int'(tdec);
      q   = num / int'(d);
      r   = f ? int'(t) + q : int'(t) - q;
      if (r <= int'(tlow) && r >= int'(tup)) begin
         t_new = 16'hFFFF;  s = 2'b11;
      end else if (r <= int'(tlow)) begin
         t_new = tlow;      s = 2'b01;
      end else if (r >= int'(tup)) begin
         t_new = tup;       s = 2'b10;
      end else begin
         t_new = DW'(r);    s = 2'b00;
      end
   endfunction

   function automatic exp_t expect_now();
      exp_t          e;
      logic [DW-1:0] t_new;
      logic [1:0]    s;
      for (int k = 0; k < CH; k++) begin
         lane_model(tx[k*DW +: DW], fx[k], dmin[k*DW +: DW], t_new, s);
         e.tnx[k*DW +: DW] = t_new;
         e.tsat[2*k +: 2]  = s;
      end
      return e;
   endfunction

   // Scoreboard for the randomized stream
   always @(posedge clk) begin
      #1;
      if (sb_en && ce && !rst) begin
         if (tnv) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow actual=tnv_1 required=no_output (t=%0t)", $time);
            end else begin
               sb_e = sb_q.pop_front();
               $display("beat out tnx=%h tsat=%b", tnx, tsat);
               check("sb_tnx", 64'(tnx), 64'(sb_e.tnx));
               check("sb_tsat", 64'(tsat), 64'(sb_e.tsat));
            end
         end
         if (tv) sb_q.push_back(expect_now());
      end
   end

   task automatic send_vec(input vec_t v, input int idx);
      exp_t e;
      int   lat;
      @(negedge clk);
      tinc = v.tinc;  tdec = v.tdec;  tup = v.tup;  tlow = v.tlow;
      tx[DW-1:0] = v.tx;  fx[0] = v.fx;  dmin[DW-1:0] = v.dmin;
      for (int k = 1; k < CH; k++) begin
         tx[k*DW +: DW]   = DW'($urandom);
         fx[k]            = 1'($urandom_range(0, 1));
         dmin[k*DW +: DW] = DW'($urandom_range(0, 9));
      end
      e  = expect_now();
      tv = 1'b1;
      ce = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      @(negedge clk);
      tv = 1'b0;
      while (tnv !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      $display("vec %0d: lat=%0d tnx=%h tsat=%b", idx, lat, tnx, tsat);
      check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(L));
      check($sformatf("vec%0d_lane0_tnx", idx), 64'(tnx[DW-1:0]), 64'(v.exp_tnx));
      check($sformatf("vec%0d_lane0_tsat", idx), 64'(tsat[1:0]), 64'(v.exp_tsat));
      check($sformatf("vec%0d_all_tnx", idx), 64'(tnx), 64'(e.tnx));
      check($sformatf("vec%0d_all_tsat", idx), 64'(tsat), 64'(e.tsat));
      @(posedge clk); #1;
      check($sformatf("vec%0d_single_tnv", idx), 64'(tnv), 64'(0));
   endtask

   initial begin
      int stale;
      checks   = 0;
      failures = 0;
      sb_en    = 1'b0;
      rst = 1'b1;  ce = 1'b1;  tv = 1'b0;
      tx = '0;  fx = '0;  dmin = '0;
      tinc = '0;  tdec = '0;  tup = '0;  tlow = '0;
`ifdef LEARNING_RATE_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_tnv", 64'(tnv), 64'(0));
      check("rst_tnx", 64'(tnx), 64'(0));
      check("rst_tsat", 64'(tsat), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      //        tx        fx    dmin    tinc      tdec      tup       tlow      exp_tnx   tsat
      vt[0] = '{16'h0400, 1'b1, 16'd2,  16'h0100, 16'h0300, 16'h2000, 16'h0200, 16'h0480, 2'b00};
      vt[1] = '{16'h0400, 1'b0, 16'd1,  16'h0100, 16'h0300, 16'h2000, 16'h0200, 16'h0200, 2'b01};
      vt[2] = '{16'h0100, 1'b0, 16'd1,  16'h0100, 16'h0300, 16'h2000, 16'h0200, 16'h0200, 2'b01};
      vt[3] = '{16'h0400, 1'b1, 16'd0,  16'h0100, 16'h0300, 16'h2000, 16'h0200, 16'h2000, 2'b10};
      vt[4] = '{16'h0400, 1'b0, 16'd0,  16'h0100, 16'h0300, 16'h2000, 16'h0200, 16'h0200, 2'b01};
      vt[5] = '{16'hFF00, 1'b1, 16'd1,  16'hFFFF, 16'h0300, 16'hF000, 16'h0200, 16'hF000, 2'b10};
      vt[6] = '{16'h0100, 1'b1, 16'd1,  16'h0100, 16'h0300, 16'h0100, 16'h0300, 16'hFFFF, 2'b11};
      vt[7] = '{16'h1000, 1'b0, 16'd3,  16'h0100, 16'h0300, 16'h2000, 16'h0200, 16'h0F00, 2'b00};
      vt[8] = '{16'h1F00, 1'b1, 16'd1,  16'h0100, 16'h0300, 16'h2000, 16'h0200, 16'h2000, 2'b10};
      vt[9] = '{16'h0800, 1'b1, 16'h10, 16'h00FF, 16'h0300, 16'h2000, 16'h0200, 16'h080F, 2'b00};

      for (int i = 0; i < 10; i++) send_vec(vt[i], i);

`ifdef LEARNING_RATE_STATS_EN
      @(negedge clk);
      stat_clr = 1'b1;
      @(posedge clk); #1;
      check("stat_clr_up", 64'(cnt_up), 64'(0));
      check("stat_clr_low", 64'(cnt_low), 64'(0));
      @(negedge clk);
      stat_clr = 1'b0;
`endif

      // ---- three back-to-back beats with a 5-cycle ce stall mid-flight
      fork
         begin
            for (int b = 0; b < 3; b++) begin
               @(negedge clk);
               tinc = 16'h0100;  tdec = 16'h0300;  tup = 16'h2000;  tlow = 16'h0200;
               for (int k = 0; k < CH; k++) begin
                  tx[k*DW +: DW]   = DW'(16'h0400 + b * 16'h0100 + k * 16'h0010);
                  fx[k]            = 1'b1;
                  dmin[k*DW +: DW] = DW'(2);
               end
               exp_v.push_back(expect_now().tnx);
               tv = 1'b1;
            end
            @(negedge clk);
            tv = 1'b0;
            repeat (7) @(negedge clk);
            ce = 1'b0;
            repeat (5) @(negedge clk);
            ce = 1'b1;
         end
         begin
            for (int c = 0; c < 60; c++) begin
               @(posedge clk); #1;
               if (ce) begin
                  if (tv) acc_c.push_back(cyc);
                  if (tnv) begin
                     out_c.push_back(cyc);
                     out_v.push_back(tnx);
                  end
               end
            end
         end
      join
      $display("stall: accepted=%0d outputs=%0d", acc_c.size(), out_c.size());
      check("stall_out_count", 64'(out_c.size()), 64'(3));
      for (int b = 0; b < 3; b++) begin
         if (b < out_c.size() && b < acc_c.size()) begin
            check($sformatf("stall_cycle%0d", b), 64'(out_c[b]), 64'(acc_c[b] + L - 1 + 5));
            check($sformatf("stall_tnx%0d", b), 64'(out_v[b]), 64'(exp_v[b]));
         end
      end

      // ---- reset with four beats in flight
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         for (int k = 0; k < CH; k++) begin
            tx[k*DW +: DW]   = DW'($urandom);
            fx[k]            = 1'($urandom_range(0, 1));
            dmin[k*DW +: DW] = DW'($urandom_range(1, 5));
         end
         tv = 1'b1;
      end
      @(negedge clk);
      tv = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_tnv", 64'(tnv), 64'(0));
      check("midrst_tnx", 64'(tnx), 64'(0));
      check("midrst_tsat", 64'(tsat), 64'(0));
`ifdef LEARNING_RATE_STATS_EN
      check("midrst_cnt_up", 64'(cnt_up), 64'(0));
      check("midrst_cnt_low", 64'(cnt_low), 64'(0));
`endif
      @(negedge clk);
      rst   = 1'b0;
      stale = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (tnv) stale++;
      end
      $display("after reset: stale outputs=%0d", stale);
      check("no_stale_tnv", 64'(stale), 64'(0));
      send_vec(vt[0], 100);

      // ---- randomized streams against the model
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         tinc = DW'($urandom);
         tdec = DW'($urandom);
         if (b == 2) begin
            tup  = DW'($urandom_range(0, 16'h1000));
            tlow = DW'($urandom_range(16'h3000, 16'h8000));
         end else begin
            tlow = DW'($urandom_range(0, 16'h6000));
            tup  = DW'(int'(tlow) + $urandom_range(1, 16'h9000));
         end
         sb_en = 1'b1;
         repeat (250) begin
            @(negedge clk);
            ce = ($urandom_range(0, 3) != 0);
            tv = 1'($urandom_range(0, 1));
            for (int k = 0; k < CH; k++) begin
               tx[k*DW +: DW]   = DW'($urandom);
               fx[k]            = 1'($urandom_range(0, 1));
               dmin[k*DW +: DW] = ($urandom_range(0, 7) == 0) ? DW'(0) : DW'($urandom_range(1, 300));
            end
         end
         @(negedge clk);
         tv = 1'b0;
         ce = 1'b1;
         repeat (25) @(negedge clk);
         check($sformatf("sb_drain%0d", b), 64'(sb_q.size()), 64'(0));
         sb_en = 1'b0;
         sb_q.delete();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
